dmem_responder: RTL

//   Multi-cycle data-memory responder: the memory side of the load/store interface the core drives.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store channel between the core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, byte-lane merged stores,
// sign/zero-extended loads, replies held until the consumer takes them.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 1 : 0);
    localparam logic [63:0]   LIMIT    = 64'(DEPTH) << 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d, live, acc;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [63:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          do_access;
    logic          mem_we;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] acc_word;
    logic [2:0]    lane;
    logic [7:0]    lmask;
    logic [2:0]    amask;
    logic [7:0]    bmask;
    logic [63:0]   word_rd, shifted, wsh, merged, load_val;
    logic          acc_err;

    assign live = '{write: bus.req_write, size: bus.req_size, uns: bus.req_unsigned,
                    addr: bus.req_addr, wdata: bus.req_wdata};

    // With single-cycle latency the access happens on the accepting edge, from live inputs.
    always_comb begin
        acc = req_q;
        if (state_q == IDLE) acc = live;
    end

    // Address decode, error detection, store merge and load extension.
    always_comb begin
        acc_word = acc.addr[3 +: AW];
        lane     = acc.addr[2:0];
        case (acc.size)
            2'd0:    begin lmask = 8'h01; amask = 3'b000; end
            2'd1:    begin lmask = 8'h03; amask = 3'b001; end
            2'd2:    begin lmask = 8'h0F; amask = 3'b011; end
            default: begin lmask = 8'hFF; amask = 3'b111; end
        endcase
        acc_err = (|(lane & amask)) || (acc.addr >= LIMIT);
        word_rd = mem[acc_word];
        bmask   = lmask << lane;
        wsh     = acc.wdata << {lane, 3'b000};
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = bmask[i] ? wsh[8*i +: 8] : word_rd[8*i +: 8];
        end
        shifted = word_rd >> {lane, 3'b000};
        case (acc.size)
            2'd0:    load_val = acc.uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    load_val = acc.uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    load_val = acc.uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        do_access   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_d       = live;
                    req_ready_d = 1'b0;
                    if (LATENCY <= 1) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc.write) ? 64'd0 : load_val;
        end
    end

    assign mem_we = do_access && acc.write && !acc_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
        end else if (mem_we) begin
            mem[acc_word] <= merged;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
